// File: rtl/frame_disassembly.sv
// Serial frame receiver: hunts for the sync word, shifts in a MSB-first payload, checks parity.
// Optional frame/parity-error statistics are enabled with FRAME_DISASSEMBLY_STATS_EN.
module frame_disassembly #(
   parameter int unsigned             DATA_W     = 28,
   parameter int unsigned             SYNC_W     = 8,
   parameter logic [SYNC_W-1:0]       SYNC_WORD  = 8'hA5,
   parameter bit                      PARITY_ODD = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              din,
   input  logic              vin,
   output logic [DATA_W-1:0] dout,
   output logic              vout,
   output logic              perr,
   output logic              busy
`ifdef FRAME_DISASSEMBLY_STATS_EN
   ,
   output logic [15:0]       frame_cnt,
   output logic [15:0]       perr_cnt,
   input  logic              stats_clr
`endif
);

   localparam int unsigned CNT_W = $clog2(DATA_W);

   typedef enum logic [1:0] {HUNT, PAYLOAD, PARITY} state_t;

   state_t            state, state_nxt;
   logic [SYNC_W-1:0] sreg;
   logic [SYNC_W-1:0] sreg_shift;
   logic [DATA_W-1:0] pay;
   logic [CNT_W-1:0]  cnt;
   logic              deliver;
   logic              err;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= HUNT;
      else      state <= state_nxt;
   end

   // Next state and frame-complete strobe
   always_comb begin
      state_nxt  = state;
      deliver    = 1'b0;
      sreg_shift = {sreg[SYNC_W-2:0], din};
      err        = ((^pay) ^ din) != PARITY_ODD;
      case (state)
         HUNT:    if (vin && sreg_shift == SYNC_WORD) state_nxt = PAYLOAD;
         PAYLOAD: if (vin && cnt == CNT_W'(DATA_W-1)) state_nxt = PARITY;
         PARITY:  if (vin) begin
                     state_nxt = HUNT;
                     deliver   = 1'b1;
                  end
         default: state_nxt = HUNT;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sreg <= '0;
         pay  <= '0;
         cnt  <= '0;
         dout <= '0;
         vout <= 1'b0;
         perr <= 1'b0;
         busy <= 1'b0;
      end else begin
         vout <= deliver;
         busy <= (state_nxt != HUNT);
         if (vin) begin
            case (state)
               HUNT: begin
                  sreg <= sreg_shift;
                  cnt  <= '0;
               end
               PAYLOAD: begin
                  pay <= {pay[DATA_W-2:0], din};
                  cnt <= cnt + CNT_W'(1);
               end
               PARITY: sreg <= '0;  // no sync overlap with the finished frame
               default: sreg <= '0;
            endcase
         end
         if (deliver) begin
            dout <= pay;
            perr <= err;
         end
      end
   end

`ifdef FRAME_DISASSEMBLY_STATS_EN
   // Saturating counters; clear takes effect before a same-cycle increment
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_cnt <= '0;
         perr_cnt  <= '0;
      end else begin
         if (stats_clr)
            frame_cnt <= deliver ? 16'd1 : 16'd0;
         else if (deliver && frame_cnt != 16'hFFFF)
            frame_cnt <= frame_cnt + 16'd1;

         if (stats_clr)
            perr_cnt <= (deliver && err) ? 16'd1 : 16'd0;
         else if (deliver && err && perr_cnt != 16'hFFFF)
            perr_cnt <= perr_cnt + 16'd1;
      end
   end
`endif

endmodule
